uart_byte_tx: RTL and testbench

//   Byte-stream UART transmitter that drives the board-level TX pin (io_out[7]).

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_byte_tx.sv | 140 ++++++++++++++
 tb/tb_uart_byte_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM encoding, frame
// geometry and the baud divider calculation.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int baud_div(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head-of-queue
// output that is valid whenever the FIFO is non-empty.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign count      = wr_ptr - rd_ptr;
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign rd_ptr_nxt = rd_ptr + (AW + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // The head register is refreshed every edge; when the new head is the slot
    // being written this cycle, the write data bypasses the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            wr_ptr  <= wr_ptr + (AW + 1)'(do_push);
            rd_ptr  <= rd_ptr_nxt;
            rd_data <= (do_push && (wr_ptr == rd_ptr_nxt)) ? wr_data
                                                           : mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART transmitter: bytes arrive over valid/ready into a FIFO and
// are serialised LSB first on a registered, idle-high tx_pin.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx_pin,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = baud_div(CLOCK_RATE, BAUD_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(DIV - 1);
    localparam logic [2:0]       LAST_DATA_BIT = 3'(UART_FRAME_BITS - 3);

    if (DIV < 2) begin : g_div_check
        $error("uart_byte_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
    end

    uart_state_t                state, state_next;
    logic [DIV_W-1:0]           div_cnt, div_next;
    logic [2:0]                 bit_cnt, bit_next;
    logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
    logic                       tx_next;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [7:0]                 fifo_rd_data;

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign busy      = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_pin    <= 1'b1;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            tx_pin    <= tx_next;
        end
    end

    // tx_pin follows the current state one clock later, so every bit keeps
    // the same DIV-cycle width including the back-to-back STOP->START hop.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rd_data;
                    div_next   = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    state_next = DATA;
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == LAST_DATA_BIT) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rd_data;
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: accepted bytes go into a scoreboard
// queue and a line monitor decodes every 8N1 frame and compares in order.
module tb_uart_byte_tx;

    localparam int DIV         = 10;
    localparam int FRAME_CYC   = 10 * DIV;
    localparam int WAIT_LIMIT  = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx_pin;
    logic       busy;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;

    uart_byte_tx #(
        .CLOCK_RATE (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_pin     (tx_pin),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out waiting for the DUT", name);
    endtask

    // Called at a falling edge; holds in_valid until the byte is taken and
    // records it in the scoreboard on the accepting rising edge.
    task automatic apply_stimulus(input logic [7:0] b);
        int  waited = 0;
        bit  taken  = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!taken && waited < WAIT_LIMIT) begin
            taken = in_ready;
            @(posedge clk);
            if (taken) exp_q.push_back(b);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        if (!taken) fail_timeout("apply_stimulus");
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) fail_timeout(name);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: decodes each frame from the pin and checks every bit is
    // exactly DIV samples wide.
    initial begin
        bit [FRAME_CYC-1:0] samples;
        logic [7:0]         data;
        bit                 shape_ok;
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx_pin == 1'b0) begin
                samples[0] = tx_pin;
                for (int i = 1; i < FRAME_CYC; i++) begin
                    @(negedge clk);
                    samples[i] = tx_pin;
                end
                shape_ok = 1'b1;
                for (int i = 0; i < DIV; i++) begin
                    if (samples[i] != 1'b0) shape_ok = 1'b0;
                    if (samples[9 * DIV + i] != 1'b1) shape_ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    data[b] = samples[DIV + DIV * b];
                    for (int j = 1; j < DIV; j++) begin
                        if (samples[DIV + DIV * b + j] != data[b]) shape_ok = 1'b0;
                    end
                end
                check_output("frame_bit_periods", int'(shape_ok), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame actual=%02h required=none", data);
                end else begin
                    check_output("frame_data", int'(data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL global_timeout simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int        first_low;
        int        busy_len;
        bit        busy_done;
        int        n;
        int        lows;
        int        busy_hi;
        bit [199:0] tx_s;

        repeat (3) @(negedge clk);
        check_output("reset_tx_pin", int'(tx_pin), 1);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_fifo_count", int'(fifo_count), 0);
        check_output("reset_in_ready", int'(in_ready), 1);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0x55 latency and busy window");
        apply_stimulus(8'h55);
        first_low = -1;
        busy_len  = 0;
        busy_done = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (first_low < 0 && tx_pin == 1'b0) first_low = k;
            if (!busy_done) begin
                if (busy) busy_len++;
                else busy_done = 1'b1;
            end
            @(negedge clk);
        end
        check_output("t1_start_latency", first_low, 2);
        check_output("t1_busy_cycles", busy_len, 101);
        wait_idle("t1_idle");

        $display("[TB] back-to-back 0xA3 0x0F");
        apply_stimulus(8'hA3);
        apply_stimulus(8'h0F);
        n = 0;
        while (tx_pin != 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_timeout("t2_first_start");
        busy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            tx_s[i] = tx_pin;
            if (busy) busy_hi++;
            @(negedge clk);
        end
        check_output("t2_last_stop_sample", int'(tx_s[99]), 1);
        check_output("t2_second_start_no_gap", int'(tx_s[100]), 0);
        check_output("t2_busy_contiguous", busy_hi, 199);
        wait_idle("t2_idle");

        $display("[TB] backpressure with six held bytes");
        fork
            begin
                for (int i = 0; i < 6; i++) apply_stimulus(8'($urandom));
            end
            begin
                n = 0;
                while (fifo_count != 3'd4 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check_output("t3_full_count", int'(fifo_count), 4);
                check_output("t3_in_ready_when_full", int'(in_ready), 0);
                n = 0;
                while (fifo_count == 3'd4 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check_output("t5_count_after_pop_from_full", int'(fifo_count), 3);
                check_output("t5_in_ready_after_pop", int'(in_ready), 1);
                @(negedge clk);
                check_output("t5_held_byte_accepted", int'(fifo_count), 4);
            end
        join
        wait_idle("t3_idle");

        $display("[TB] 200 random bytes with random gaps");
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            apply_stimulus(8'($urandom));
        end
        wait_idle("t6_idle");

        $display("[TB] reset during data bit 3 of 0xFF");
        mon_en = 1'b0;
        apply_stimulus(8'hFF);
        apply_stimulus(8'h3C);
        n = 0;
        while (tx_pin != 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_timeout("t4_start");
        repeat (DIV + 3 * DIV + 5) @(negedge clk);
        check_output("t4_count_before_reset", int'(fifo_count), 1);
        reset = 1'b0;
        #1;
        check_output("t4_tx_pin_in_reset", int'(tx_pin), 1);
        check_output("t4_fifo_count_in_reset", int'(fifo_count), 0);
        check_output("t4_busy_in_reset", int'(busy), 0);
        check_output("t4_in_ready_in_reset", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        lows = 0;
        busy_hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_pin == 1'b0) lows++;
            if (busy) busy_hi++;
        end
        check_output("t4_tx_low_after_release", lows, 0);
        check_output("t4_busy_after_release", busy_hi, 0);
        mon_en = 1'b1;
        apply_stimulus(8'h96);
        wait_idle("t4_idle");
        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
